xnr_parity_pipe: RTL

Pipelined, parametrised N-input XNOR/XOR parity reduction unit with valid/ready handshaking. It generalises the 3-input XNOR cell into a WIDTH-input reduction tree built from radix-3 stages, with one register per tree level. The block sits in the ADPLL digital datapath, where it produces parity and lock-check words for the TDC/DCO control bus. An optional multi-beat accumulate mode covers words wider than WIDTH.

---
 rtl/xnr_parity_pipe.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/xnr_parity_pipe.sv
// xnr_parity_pipe: pipelined WIDTH-input XOR/XNOR parity reduction tree.
//
// The tree is built from radix-3 levels with one register per level, so a beat
// takes STAGES = ceil(log3(WIDTH)) cycles from acceptance to out_valid. Every
// stage advances together when adv = !out_valid || out_ready. Empty stages are
// not collapsed.
//
// Optional feature (compile-time macro XNR_PIPE_ACCUM_EN): the final stage
// holds a 1-bit accumulator. Beats with acc_en=1 fold into it until the beat
// flagged in_last, which emits the group parity. Without the macro, acc_en and
// in_last are ignored and every accepted beat produces one result.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready (equals adv)
//   in_data    word to reduce
//   in_mode    0 = XNOR, 1 = XOR
//   in_last    last beat of an accumulated group
//   acc_en     accumulate this beat
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_par    parity result

module xnr_parity_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_last,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_par
);

    function automatic int unsigned clog3(input int unsigned w);
        int unsigned s;
        int unsigned c;
        s = 0;
        c = 1;
        while (c < w) begin
            c = c * 3;
            s = s + 1;
        end
        return s;
    endfunction

    localparam int unsigned STAGES = clog3(WIDTH);
    localparam int unsigned VEC_N  = (STAGES > 1) ? STAGES - 1 : 1;

    // One radix-3 level: bit i folds into bit i/3. Missing leaves stay 0, so
    // repeated application keeps all upper bits zero.
    function automatic logic [WIDTH-1:0] reduce3(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i/3] = r[i/3] ^ v[i];
        end
        return r;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] fin_vec;
    logic             fin_vld;
    logic             fin_mode;
    logic             fin_bit;
    logic             out_valid_q, out_valid_d;
    logic             out_par_q, out_par_d;

`ifdef XNR_PIPE_ACCUM_EN
    logic fin_acc_en;
    logic fin_last;
    logic acc_q, acc_d;
`else
    logic unused_accum;
    assign unused_accum = acc_en ^ in_last;
`endif

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_par   = out_par_q;

    // Intermediate levels; the last level is the output register below.
    if (STAGES > 1) begin : g_tree
        logic [WIDTH-1:0] vec_q [VEC_N];
        logic [VEC_N-1:0] vld_q;
        logic [VEC_N-1:0] mode_q;
`ifdef XNR_PIPE_ACCUM_EN
        logic [VEC_N-1:0] acc_en_q;
        logic [VEC_N-1:0] last_q;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
            end else if (adv) begin
                vld_q[0]  <= in_valid;
                vec_q[0]  <= reduce3(in_data);
                mode_q[0] <= in_mode;
`ifdef XNR_PIPE_ACCUM_EN
                acc_en_q[0] <= acc_en;
                last_q[0]   <= in_last;
`endif
                for (int s = 1; s < int'(VEC_N); s++) begin
                    vld_q[s]  <= vld_q[s-1];
                    vec_q[s]  <= reduce3(vec_q[s-1]);
                    mode_q[s] <= mode_q[s-1];
`ifdef XNR_PIPE_ACCUM_EN
                    acc_en_q[s] <= acc_en_q[s-1];
                    last_q[s]   <= last_q[s-1];
`endif
                end
            end
        end

        assign fin_vec  = vec_q[VEC_N-1];
        assign fin_vld  = vld_q[VEC_N-1];
        assign fin_mode = mode_q[VEC_N-1];
`ifdef XNR_PIPE_ACCUM_EN
        assign fin_acc_en = acc_en_q[VEC_N-1];
        assign fin_last   = last_q[VEC_N-1];
`endif
    end else begin : g_flat
        assign fin_vec  = in_data;
        assign fin_vld  = in_valid;
        assign fin_mode = in_mode;
`ifdef XNR_PIPE_ACCUM_EN
        assign fin_acc_en = acc_en;
        assign fin_last   = in_last;
`endif
    end

    always_comb begin
        // At the last level at most the low three bits can be nonzero.
        fin_bit     = ^fin_vec;
        out_valid_d = out_valid_q;
        out_par_d   = out_par_q;
`ifdef XNR_PIPE_ACCUM_EN
        acc_d       = acc_q;
`endif
        if (adv) begin
            out_valid_d = fin_vld;
            if (fin_vld) begin
`ifdef XNR_PIPE_ACCUM_EN
                if (fin_acc_en && !fin_last) begin
                    // Absorbed beat: no result emitted.
                    acc_d       = acc_q ^ fin_bit;
                    out_valid_d = 1'b0;
                end else if (fin_acc_en) begin
                    out_par_d = acc_q ^ fin_bit ^ ~fin_mode;
                    acc_d     = 1'b0;
                end else begin
                    out_par_d = fin_bit ^ ~fin_mode;
                end
`else
                out_par_d = fin_bit ^ ~fin_mode;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_par_q   <= 1'b0;
`ifdef XNR_PIPE_ACCUM_EN
            acc_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_par_q   <= out_par_d;
`ifdef XNR_PIPE_ACCUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

endmodule
